child_report_collector: RTL and testbench

//   Upstream counterpart to the parent-to-child instance tree: gathers report words from
//   NUM_CHILD child instances and serialises them into one stream toward the parent.

---
 rtl/child_report_collector.sv | 131 +++++++++++++
 tb/tb_child_report_collector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/child_report_collector.sv
// Round-robin collector: merges report words from NUM_CHILD valid/ready children into one
// registered upstream stream tagged with the source index. Optional macro: COLLECT_STATS_EN.
module child_report_collector #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CHILD-1:0]        child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic [NUM_CHILD-1:0]        child_ready,
    output logic                        up_valid,
    input  logic                        up_ready,
    output logic [DATA_W-1:0]           up_data,
    output logic [IDX_W-1:0]            up_idx,
    output logic                        busy
`ifdef COLLECT_STATS_EN
    ,
    output logic [31:0]                 stat_count
`endif
);

    localparam int SEL_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t        state_reg;
    out_state_t        state_next;
    logic [DATA_W-1:0] up_data_reg;
    logic [IDX_W-1:0]  up_idx_reg;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [IDX_W-1:0]  rr_ptr_next;

    logic [DATA_W-1:0] child_word [NUM_CHILD];
    logic              grant_found;
    logic [SEL_W-1:0]  grant_sel;
    logic [DATA_W-1:0] grant_data;
    logic              load_ok;
    logic              grant_en;
    logic              accept;
    int                cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHILD; gi++) begin : g_child
            assign child_word[gi]  = child_data[gi*DATA_W +: DATA_W];
            assign child_ready[gi] = grant_en && (grant_sel == SEL_W'(gi));
        end
    endgenerate

    // First valid child at or after rr_ptr, wrapping modulo NUM_CHILD.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        grant_data  = '0;
        cand        = 0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_CHILD) begin
                cand = cand - NUM_CHILD;
            end
            if (!grant_found && child_valid[cand[SEL_W-1:0]]) begin
                grant_found = 1'b1;
                grant_sel   = cand[SEL_W-1:0];
                grant_data  = child_word[cand[SEL_W-1:0]];
            end
        end
    end

    // A grant is only a completed transfer, so no handshake may happen during reset.
    assign grant_en    = !rst && load_ok && grant_found;
    assign rr_ptr_next = (grant_sel == SEL_W'(NUM_CHILD - 1)) ? '0
                                                              : IDX_W'(grant_sel) + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (grant_en) begin
            state_next = FULL;
        end else if (accept) begin
            state_next = EMPTY;
        end
    end

    always_comb begin
        up_valid = (state_reg == FULL);
        accept   = up_valid && up_ready;
        load_ok  = !up_valid || up_ready;
        busy     = up_valid || (|child_valid);
        up_data  = up_data_reg;
        up_idx   = up_idx_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_data_reg <= '0;
            up_idx_reg  <= '0;
            rr_ptr_reg  <= '0;
        end else if (grant_en) begin
            up_data_reg <= grant_data;
            up_idx_reg  <= IDX_W'(grant_sel);
            rr_ptr_reg  <= rr_ptr_next;
        end
    end

`ifdef COLLECT_STATS_EN
    logic [31:0] stat_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_count_reg <= '0;
        end else if (accept && (stat_count_reg != 32'hFFFF_FFFF)) begin
            stat_count_reg <= stat_count_reg + 32'd1;
        end
    end

    assign stat_count = stat_count_reg;
`endif

endmodule

// File: tb/tb_child_report_collector.sv
// Bench for child_report_collector: directed scenarios plus a random phase, all checked
// every cycle against a queue-free arithmetic model of the arbitration rules.
module tb_child_report_collector;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    child_valid = '0;
    logic [N*DW-1:0] child_data = '0;
    logic [N-1:0]    child_ready;
    logic            up_valid;
    logic            up_ready = 1'b0;
    logic [DW-1:0]   up_data;
    logic [IW-1:0]   up_idx;
    logic            busy;
`ifdef COLLECT_STATS_EN
    logic [31:0]     stat_count;
`endif

    int assert_count = 0;
    int fail_count   = 0;

    // Reference model state
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    int            m_idx   = 0;
    int            m_ptr   = 0;
    logic [31:0]   m_stat  = '0;

    child_report_collector #(.NUM_CHILD(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_data     (up_data),
        .up_idx      (up_idx),
        .busy        (busy)
`ifdef COLLECT_STATS_EN
        ,
        .stat_count  (stat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic r, input logic [N-1:0] cv, input logic ur);
        if (r || (m_valid && !ur)) return -1;
        for (int k = 0; k < N; k++) begin
            if (cv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*DW-1:0] rand_data();
        logic [N*DW-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    // Drive one cycle at the falling edge, compare all outputs, then advance the model.
    task automatic step(input logic r, input logic [N-1:0] cv, input logic ur,
                        input logic [N*DW-1:0] cd);
        int           g;
        logic [N-1:0] one;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        rst         = r;
        child_valid = cv;
        up_ready    = ur;
        child_data  = cd;
        #1;
        g         = model_grant(r, cv, ur);
        one       = 1;
        exp_ready = (g >= 0) ? (one << g) : '0;
        check("child_ready", 32'(child_ready), 32'(exp_ready));
        check("up_valid", 32'(up_valid), 32'(m_valid));
        check("up_data", 32'(up_data), 32'(m_data));
        check("up_idx", 32'(up_idx), 32'(m_idx));
        check("busy", 32'(busy), 32'(m_valid | (|cv)));
`ifdef COLLECT_STATS_EN
        check("stat_count", stat_count, m_stat);
`endif
        if (r) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_idx   = 0;
            m_ptr   = 0;
            m_stat  = '0;
        end else begin
            if (m_valid && ur && m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 1;
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = cd[g*DW +: DW];
                m_idx   = g;
                m_ptr   = (g + 1) % N;
            end else if (m_valid && ur) begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial begin
        logic [N*DW-1:0] d;

        // Reset: outputs cleared, no grant while rst is high
        step(1'b1, 5'b10101, 1'b1, rand_data());
        check("reset_ready", 32'(child_ready), 32'h0);
        step(1'b1, '0, 1'b1, rand_data());
        check("reset_up_valid", 32'(up_valid), 32'h0);
        check("reset_up_data", 32'(up_data), 32'h0);

        // Single child 2 with a known word
        d = rand_data();
        d[2*DW +: DW] = 16'hA5A5;
        step(1'b0, 5'b00100, 1'b1, d);
        check("t1_ready", 32'(child_ready), 32'h04);
        step(1'b0, 5'b00000, 1'b1, rand_data());
        check("t1_up_valid", 32'(up_valid), 32'h1);
        check("t1_up_data", 32'(up_data), 32'hA5A5);
        check("t1_up_idx", 32'(up_idx), 32'h2);

        // All children valid, parent always ready: 0,1,2,3,4,0,1 back to back
        step(1'b1, '0, 1'b1, rand_data());
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 5'b11111, 1'b1, rand_data());
            if (i >= 1) begin
                check("t2_up_valid", 32'(up_valid), 32'h1);
                check("t2_up_idx", 32'(up_idx), 32'((i - 1) % N));
            end
        end

        // Backpressure: word from child 1 held, no grants
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 5'b11111, 1'b0, rand_data());
            check("t3_ready_held", 32'(child_ready), 32'h0);
            check("t3_idx_held", 32'(up_idx), 32'h1);
        end
        step(1'b0, 5'b11111, 1'b1, rand_data());
        check("t3_release_ready", 32'(child_ready), 32'h04);
        step(1'b0, 5'b00011, 1'b1, rand_data());
        check("t3_next_idx", 32'(up_idx), 32'h2);

        // Pointer now 3: wrap search gives child 0, then child 1
        check("t4_wrap_ready", 32'(child_ready), 32'h01);
        step(1'b0, 5'b00011, 1'b1, rand_data());
        check("t4_second_ready", 32'(child_ready), 32'h02);
        check("t4_idx0", 32'(up_idx), 32'h0);
        step(1'b0, 5'b00000, 1'b0, rand_data());
        check("t4_idx1", 32'(up_idx), 32'h1);

        // Reset while FULL; first grant afterwards searches from child 0
        step(1'b1, 5'b11111, 1'b0, rand_data());
        check("t5_ready_in_reset", 32'(child_ready), 32'h0);
        step(1'b0, 5'b10010, 1'b1, rand_data());
        check("t5_up_valid", 32'(up_valid), 32'h0);
        check("t5_up_idx", 32'(up_idx), 32'h0);
        check("t5_first_grant", 32'(child_ready), 32'h02);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), N'($urandom), ($urandom_range(0, 9) < 7),
                 rand_data());
        end

`ifdef COLLECT_STATS_EN
        step(1'b1, '0, 1'b1, rand_data());
        for (int i = 0; i < 11; i++) step(1'b0, 5'b11111, 1'b1, rand_data());
        step(1'b0, '0, 1'b0, rand_data());
        check("t6_count10", stat_count, 32'd10);
        step(1'b1, '0, 1'b0, rand_data());
        step(1'b0, '0, 1'b0, rand_data());
        check("t6_count_reset", stat_count, 32'd0);
        dut.stat_count_reg = 32'hFFFF_FFFD;
        m_stat = 32'hFFFF_FFFD;
        for (int i = 0; i < 6; i++) step(1'b0, 5'b11111, 1'b1, rand_data());
        check("t6_saturate", stat_count, 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
